// File: rtl/dmem_lsu_ctrl.sv
// Data-memory load/store controller between EX/MEM and a block-RAM data
// memory. One request in flight; word-crossing accesses are split into two
// back-to-back RAM accesses. Lanes are big-endian (offset 0 -> top lane).
module dmem_lsu_ctrl #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_wea,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err
);
    localparam int NB  = DATA_W / 8;
    localparam int LNB = $clog2(NB);

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;

    state_t state_q, state_d;

    // Registered request fields (captured on the handshake)
    logic                  we_p0, uns_p0, err_p0, split_p0;
    logic [3:0]            sb_p0;
    logic [LNB-1:0]        off_p0;
    logic [DATA_W-1:0]     wdata_p0;
    logic [ADDR_W-1:0]     mem_addr_q;

    // Read capture
    logic [DATA_W-1:0]     rd0_p1, rdata_p1;

    logic                  hs, req_err, req_split, size_ok, misal;
    logic [3:0]            req_sb;
    logic [LNB-1:0]        req_off;
    logic [2*DATA_W-1:0]   store_win;
    logic [2*NB-1:0]       mask_win;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

    // Left-justify the value in a two-word big-endian window, then slide it
    // down to the byte offset: upper word = first RAM word, lower = second.
    function automatic logic [2*DATA_W-1:0] place_store(input logic [DATA_W-1:0] v,
                                                        input logic [3:0] sb,
                                                        input logic [LNB-1:0] off);
        logic [2*DATA_W-1:0] w;
        w = {v, {DATA_W{1'b0}}} << (DATA_W - 8 * int'(sb));
        return w >> (8 * int'(off));
    endfunction

    function automatic logic [2*NB-1:0] place_mask(input logic [3:0] sb,
                                                   input logic [LNB-1:0] off);
        logic [2*NB-1:0] m;
        m = {(2*NB){1'b1}} << (2 * NB - int'(sb));
        return m >> int'(off);
    endfunction

    // Pull the addressed bytes out of the two-word window and extend them
    function automatic logic [DATA_W-1:0] assemble_load(input logic [DATA_W-1:0] rd0,
                                                        input logic [DATA_W-1:0] rd1,
                                                        input logic [3:0] sb,
                                                        input logic [LNB-1:0] off,
                                                        input logic uns);
        logic [2*DATA_W-1:0]        w;
        logic [DATA_W-1:0]          v;
        logic signed [DATA_W-1:0]   sx;
        int                         sh;
        w  = ({rd0, rd1} << (8 * int'(off))) >> (2 * DATA_W - 8 * int'(sb));
        v  = w[DATA_W-1:0];
        sh = DATA_W - 8 * int'(sb);
        sx = signed'(v << sh);
        sx = sx >>> sh;
        return uns ? v : unsigned'(sx);
    endfunction

    assign req_ready = (state_q == IDLE) && !reset;
    assign hs        = req_valid && req_ready;
    assign req_sb    = size_bytes(req_size);
    assign req_off   = req_addr[LNB-1:0];
    assign size_ok   = (DATA_W == 64) || (req_size != 2'd3);
    assign misal     = (4'(req_off) & (req_sb - 4'd1)) != 4'd0;
    assign req_err   = !size_ok || (misal && (ALLOW_MISALIGN == 0));
    assign req_split = (int'(req_off) + int'(req_sb)) > NB;

    assign store_win = place_store(wdata_p0, sb_p0, off_p0);
    assign mask_win  = place_mask(sb_p0, off_p0);

    assign mem_addr   = mem_addr_q;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_valid && err_p0;
    assign resp_rdata = (resp_valid && !err_p0) ? rdata_p1 : '0;

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // RAM word address: loaded on an accepted request, bumped for the second word
    always_ff @(posedge clock) begin
        if (reset)
            mem_addr_q <= '0;
        else if (hs && !req_err)
            mem_addr_q <= {req_addr[ADDR_W-1:LNB], {LNB{1'b0}}};
        else if (state_q == ACC0 && split_p0)
            mem_addr_q <= mem_addr_q + ADDR_W'(NB);
    end

    // ---- stage p0: request capture ----
    always_ff @(posedge clock) begin
        if (hs) begin
            we_p0    <= req_we;
            uns_p0   <= req_unsigned;
            sb_p0    <= req_sb;
            off_p0   <= req_off;
            wdata_p0 <= req_wdata;
            err_p0   <= req_err;
            split_p0 <= req_split;
        end
    end

    // ---- stage p1: read-data capture and load assembly ----
    always_ff @(posedge clock) begin
        if (state_q == ACC1)
            rd0_p1 <= mem_rdata;
        if (state_q == CAP)
            rdata_p1 <= we_p0 ? '0
                      : assemble_load(split_p0 ? rd0_p1 : mem_rdata,
                                      split_p0 ? mem_rdata : '0,
                                      sb_p0, off_p0, uns_p0);
    end

    // Next-state and RAM strobes
    always_comb begin
        state_d   = state_q;
        mem_en    = 1'b0;
        mem_wea   = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: if (hs) state_d = req_err ? RESP : ACC0;
            ACC0: begin
                mem_en = 1'b1;
                if (we_p0) begin
                    mem_wea   = mask_win[2*NB-1:NB];
                    mem_wdata = store_win[2*DATA_W-1:DATA_W];
                end
                state_d = split_p0 ? ACC1 : CAP;
            end
            ACC1: begin
                mem_en = 1'b1;
                if (we_p0) begin
                    mem_wea   = mask_win[NB-1:0];
                    mem_wdata = store_win[DATA_W-1:0];
                end
                state_d = CAP;
            end
            CAP:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Directed bench for dmem_lsu_ctrl (DATA_W=32). Instance A allows misaligned
// accesses and talks to a small RAM model; instance B rejects them.
module tb_dmem_lsu_ctrl;
    logic        clk = 0;
    logic        reset;
    logic        va, vb;
    logic        req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready, mem_en, resp_valid, resp_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, resp_rdata;
    logic [3:0]  mem_wea;

    logic        ready_b, en_b, rv_b, err_b;
    logic [31:0] addr_b, wdata_b, rd_b;
    logic [31:0] rdata_b = '0;
    logic [3:0]  wea_b;

    logic [31:0] ram [0:4095];

    int          tests = 0, fails = 0;
    int          r_cyc, n_acc;
    logic [31:0] r_data, r_addr;
    logic        r_err;
    logic [31:0] acc_addr [0:1];
    logic [3:0]  acc_wea [0:1];
    logic [31:0] acc_wdata [0:1];

    always #5 clk = ~clk;

    dmem_lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1)) dut (
        .clock(clk), .reset(reset), .req_valid(va), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_en(mem_en),
        .mem_addr(mem_addr), .mem_wea(mem_wea), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err));

    dmem_lsu_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(0)) dut_b (
        .clock(clk), .reset(reset), .req_valid(vb), .req_ready(ready_b),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .mem_en(en_b),
        .mem_addr(addr_b), .mem_wea(wea_b), .mem_wdata(wdata_b),
        .mem_rdata(rdata_b), .resp_valid(rv_b), .resp_rdata(rd_b),
        .resp_err(err_b));

    // RAM model: registered read, per-byte write enable
    always @(posedge clk) begin
        if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_wea[b]) ram[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr[13:2]];
        end
    end

    task automatic run_req(input logic use_b, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        if (use_b) vb = 1'b1; else va = 1'b1;
        @(posedge clk);
        #1 va = 1'b0; vb = 1'b0;
        r_cyc = -1; n_acc = 0; r_data = '0; r_err = 1'b0; r_addr = '0;
        for (int c = 1; c <= 8 && r_cyc < 0; c++) begin
            @(negedge clk);
            if (use_b ? en_b : mem_en) begin
                if (n_acc < 2) begin
                    acc_addr[n_acc]  = use_b ? addr_b : mem_addr;
                    acc_wea[n_acc]   = use_b ? wea_b : mem_wea;
                    acc_wdata[n_acc] = use_b ? wdata_b : mem_wdata;
                end
                n_acc++;
            end
            if (use_b ? rv_b : resp_valid) begin
                r_cyc = c; r_data = use_b ? rd_b : resp_rdata;
                r_err = use_b ? err_b : resp_err; r_addr = use_b ? addr_b : mem_addr;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; va = 0; vb = 0;
        req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
        for (int i = 0; i < 4096; i++) ram[i] = '0;
        repeat (3) @(negedge clk);
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b exp 0", req_ready); end
        tests++; if (mem_en !== 1'b0 || mem_wea !== 4'h0) begin fails++; $display("FAIL rst_mem got en=%b wea=%b exp 0/0000", mem_en, mem_wea); end
        tests++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_addr got %h/%h exp 0/0", mem_addr, mem_wdata); end
        tests++; if (resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin fails++; $display("FAIL rst_resp got v=%b e=%b d=%h exp 0", resp_valid, resp_err, resp_rdata); end
        reset = 1'b0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_store_byte();
        run_req(0, 1, 2'd0, 0, 32'h1001, 32'h000000AB);
        tests++; if (n_acc !== 1) begin fails++; $display("FAIL sb_nacc got %0d exp 1", n_acc); end
        tests++; if (acc_addr[0] !== 32'h1000 || acc_wea[0] !== 4'b0100) begin fails++; $display("FAIL sb_acc got %h/%b exp 00001000/0100", acc_addr[0], acc_wea[0]); end
        tests++; if (acc_wdata[0] !== 32'h00AB0000) begin fails++; $display("FAIL sb_wdata got %h exp 00ab0000", acc_wdata[0]); end
        tests++; if (r_cyc !== 3 || r_err !== 1'b0 || r_data !== 32'h0) begin fails++; $display("FAIL sb_resp got cyc=%0d err=%b d=%h exp 3/0/0", r_cyc, r_err, r_data); end
        tests++; if (r_addr !== 32'h1000) begin fails++; $display("FAIL sb_addr_hold got %h exp 00001000", r_addr); end
        @(negedge clk);
        tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL sb_pulse got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
        run_req(0, 0, 2'd0, 1, 32'h1001, 32'h0);
        tests++; if (r_data !== 32'h000000AB) begin fails++; $display("FAIL lbu got %h exp 000000ab", r_data); end
        run_req(0, 0, 2'd0, 0, 32'h1001, 32'h0);
        tests++; if (r_data !== 32'hFFFFFFAB) begin fails++; $display("FAIL lb got %h exp ffffffab", r_data); end
        run_req(0, 0, 2'd1, 1, 32'h1001, 32'h0);
        tests++; if (r_data !== 32'h0000AB00 || r_cyc !== 3) begin fails++; $display("FAIL lhu_mis got %h cyc=%0d exp 0000ab00/3", r_data, r_cyc); end
    endtask

    task automatic test_load_half();
        ram[12'h800] = 32'h12348001;
        run_req(0, 0, 2'd1, 0, 32'h2002, 32'h0);
        tests++; if (r_data !== 32'hFFFF8001 || r_cyc !== 3) begin fails++; $display("FAIL lh got %h cyc=%0d exp ffff8001/3", r_data, r_cyc); end
        tests++; if (acc_wea[0] !== 4'h0 || acc_addr[0] !== 32'h2000) begin fails++; $display("FAIL lh_acc got %b/%h exp 0000/00002000", acc_wea[0], acc_addr[0]); end
        run_req(0, 0, 2'd1, 1, 32'h2002, 32'h0);
        tests++; if (r_data !== 32'h00008001) begin fails++; $display("FAIL lhu got %h exp 00008001", r_data); end
    endtask

    task automatic test_split_load();
        ram[12'hC00] = 32'hAABBCCDD; ram[12'hC01] = 32'h11223344;
        run_req(0, 0, 2'd2, 0, 32'h3003, 32'h0);
        tests++; if (n_acc !== 2 || acc_addr[0] !== 32'h3000 || acc_addr[1] !== 32'h3004) begin fails++; $display("FAIL lw_split_acc got n=%0d %h %h exp 2 00003000 00003004", n_acc, acc_addr[0], acc_addr[1]); end
        tests++; if (r_data !== 32'hDD112233 || r_cyc !== 4) begin fails++; $display("FAIL lw_split got %h cyc=%0d exp dd112233/4", r_data, r_cyc); end
    endtask

    task automatic test_back_to_back();
        run_req(0, 1, 2'd2, 0, 32'h3002, 32'hCAFEBABE);
        tests++; if (acc_addr[0] !== 32'h3000 || acc_wea[0] !== 4'b0011 || acc_wdata[0] !== 32'h0000CAFE) begin fails++; $display("FAIL sw_acc0 got %h/%b/%h exp 00003000/0011/0000cafe", acc_addr[0], acc_wea[0], acc_wdata[0]); end
        tests++; if (acc_addr[1] !== 32'h3004 || acc_wea[1] !== 4'b1100 || acc_wdata[1] !== 32'hBABE0000) begin fails++; $display("FAIL sw_acc1 got %h/%b/%h exp 00003004/1100/babe0000", acc_addr[1], acc_wea[1], acc_wdata[1]); end
        tests++; if (r_cyc !== 4 || r_err !== 1'b0) begin fails++; $display("FAIL sw_resp got cyc=%0d err=%b exp 4/0", r_cyc, r_err); end
        run_req(0, 0, 2'd2, 0, 32'h3002, 32'h0);
        tests++; if (r_data !== 32'hCAFEBABE) begin fails++; $display("FAIL sw_readback got %h exp cafebabe", r_data); end
        tests++; if (ram[12'hC00] !== 32'hAABBCAFE || ram[12'hC01] !== 32'hBABE3344) begin fails++; $display("FAIL sw_ram got %h %h exp aabbcafe babe3344", ram[12'hC00], ram[12'hC01]); end
    endtask

    task automatic test_wrap();
        ram[12'hFFF] = 32'h000000AA; ram[12'h000] = 32'h55000000;
        run_req(0, 0, 2'd1, 1, 32'hFFFFFFFF, 32'h0);
        tests++; if (acc_addr[0] !== 32'hFFFFFFFC || acc_addr[1] !== 32'h0) begin fails++; $display("FAIL wrap_acc got %h %h exp fffffffc 00000000", acc_addr[0], acc_addr[1]); end
        tests++; if (r_data !== 32'h0000AA55 || r_cyc !== 4) begin fails++; $display("FAIL wrap_data got %h cyc=%0d exp 0000aa55/4", r_data, r_cyc); end
    endtask

    task automatic test_errors();
        run_req(0, 0, 2'd3, 0, 32'h1000, 32'h0);
        tests++; if (r_cyc !== 1 || r_err !== 1'b1 || r_data !== 32'h0 || n_acc !== 0) begin fails++; $display("FAIL err_size got cyc=%0d err=%b d=%h n=%0d exp 1/1/0/0", r_cyc, r_err, r_data, n_acc); end
        run_req(1, 0, 2'd1, 0, 32'h1001, 32'h0);
        tests++; if (r_cyc !== 1 || r_err !== 1'b1 || r_data !== 32'h0 || n_acc !== 0) begin fails++; $display("FAIL err_misal got cyc=%0d err=%b d=%h n=%0d exp 1/1/0/0", r_cyc, r_err, r_data, n_acc); end
        run_req(1, 0, 2'd2, 0, 32'h1000, 32'h0);
        tests++; if (r_cyc !== 3 || r_err !== 1'b0 || n_acc !== 1) begin fails++; $display("FAIL noerr_aligned got cyc=%0d err=%b n=%0d exp 3/0/1", r_cyc, r_err, n_acc); end
    endtask

    task automatic test_reset_midway();
        ram[12'hC00] = 32'h0; ram[12'hC01] = 32'h0;
        @(negedge clk);
        req_we = 1; req_size = 2'd2; req_unsigned = 0; req_addr = 32'h3002; req_wdata = 32'h22334455; va = 1;
        @(posedge clk); #1 va = 0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (mem_en !== 1'b1 || mem_addr !== 32'h3004) begin fails++; $display("FAIL rm_acc1 got en=%b addr=%h exp 1/00003004", mem_en, mem_addr); end
        reset = 1'b1;
        @(negedge clk);
        tests++; if (mem_en !== 1'b0 || mem_wea !== 4'h0 || req_ready !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL rm_held got en=%b wea=%b rdy=%b v=%b exp 0/0000/0/0", mem_en, mem_wea, req_ready, resp_valid); end
        @(negedge clk);
        tests++; if (resp_valid !== 1'b0) begin fails++; $display("FAIL rm_noresp got %b exp 0", resp_valid); end
        reset = 1'b0;
        @(negedge clk);
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL rm_ready got %b exp 1", req_ready); end
        run_req(0, 0, 2'd2, 0, 32'h1000, 32'h0);
        tests++; if (r_data !== 32'h00AB0000 || r_cyc !== 3) begin fails++; $display("FAIL rm_after got %h cyc=%0d exp 00ab0000/3", r_data, r_cyc); end
        // reset during the first access: only the first word is written
        ram[12'hC00] = 32'h0; ram[12'hC01] = 32'h0;
        @(negedge clk);
        req_we = 1; req_size = 2'd2; req_addr = 32'h3002; req_wdata = 32'h22334455; va = 1;
        @(posedge clk); #1 va = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (ram[12'hC00] !== 32'h00002233 || ram[12'hC01] !== 32'h0) begin fails++; $display("FAIL rm_first_only got %h %h exp 00002233 00000000", ram[12'hC00], ram[12'hC01]); end
        tests++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin fails++; $display("FAIL rm_idle got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_half();
        test_split_load();
        test_back_to_back();
        test_wrap();
        test_errors();
        test_reset_midway();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
